// File: rtl/mem_align.sv
// Load/store alignment unit between the MIPS MEM stage and the word-wide data memory.
// Formats store lanes and byte enables, extends load lanes, and runs one req/ack access with timeout.
module mem_align #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic        we_r, we_s, sext_r, sext_s;
  logic [1:0]  size_r, size_s, lane_r, lane_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        busy_s, done_s, err_s, mem_req_s, mem_we_s;
  logic [31:0] rdata_s, mem_addr_s, mem_wdata_s;
  logic [3:0]  mem_be_s;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_fmt(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   be_fmt = 4'b0001 << a;
      2'b01:   be_fmt = a[1] ? 4'b1100 : 4'b0011;
      default: be_fmt = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_fmt(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   wdata_fmt = {4{d[7:0]}};
      2'b01:   wdata_fmt = {2{d[15:0]}};
      default: wdata_fmt = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then zero/sign-extend it.
  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (sz)
      2'b00:   load_ext = {{24{sx & sh[7]}}, sh[7:0]};
      2'b01:   load_ext = {{16{sx & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // Register stage: every output and all FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      we_r      <= 1'b0;
      sext_r    <= 1'b0;
      size_r    <= 2'b00;
      lane_r    <= 2'b00;
      cnt_r     <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'd0;
    end else begin
      state_r   <= state_s;
      we_r      <= we_s;
      sext_r    <= sext_s;
      size_r    <= size_s;
      lane_r    <= lane_s;
      cnt_r     <= cnt_s;
      busy      <= busy_s;
      done      <= done_s;
      err       <= err_s;
      rdata     <= rdata_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_be    <= mem_be_s;
      mem_wdata <= mem_wdata_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    we_s        = we_r;
    sext_s      = sext_r;
    size_s      = size_r;
    lane_s      = lane_r;
    cnt_s       = cnt_r;
    busy_s      = busy;
    done_s      = 1'b0;
    err_s       = err;
    rdata_s     = rdata;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_be_s    = mem_be;
    mem_wdata_s = mem_wdata;
    case (state_r)
      IDLE: begin
        if (start) begin
          we_s   = we;
          sext_s = sext;
          size_s = size;
          lane_s = addr[1:0];
          cnt_s  = 8'd0;
          busy_s = 1'b1;
          if (misaligned(size, addr[1:0])) begin
            state_s = DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s     = REQ;
            err_s       = 1'b0;
            mem_req_s   = 1'b1;
            mem_we_s    = we;
            mem_addr_s  = {addr[31:2], 2'b00};
            mem_be_s    = be_fmt(size, addr[1:0]);
            mem_wdata_s = we ? wdata_fmt(size, wdata) : 32'd0;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      REQ: begin
        // An ack on the timeout edge still completes the access cleanly.
        if (mem_ack || (cnt_r == TO_LAST)) begin
          state_s   = DONE;
          done_s    = 1'b1;
          err_s     = ~mem_ack;
          cnt_s     = 8'd0;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          mem_be_s  = 4'b0000;
          if (mem_ack && !we_r) begin
            rdata_s = load_ext(size_r, sext_r, lane_r, mem_rdata);
          end else begin
            rdata_s = rdata;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s   = IDLE;
        busy_s    = 1'b0;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        mem_be_s  = 4'b0000;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_align.sv
// Self-checking bench for mem_align: table-driven accesses with a completion scoreboard,
// plus hand-written reset, timeout and busy-start sequences.
module tb_mem_align;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          delay;
    logic        poke;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_req;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  vec_t vt[14];

  mem_align #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                              input int dly, input logic pk, input logic e, input logic [3:0] be,
                              input logic [31:0] ewd, input logic [31:0] erd, input int ereq);
    vec_t v;
    v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.mrd = mrd;
    v.delay = dly; v.poke = pk; v.exp_err = e; v.exp_be = be; v.exp_wdata = ewd;
    v.exp_rdata = erd; v.exp_req = ereq;
    return v;
  endfunction

  // Scoreboard: each done pulse retires the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_err", {31'd0, err}, {31'd0, e.err});
        check("sb_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int req_cycles;
    int cyc;
    logic [31:0] exp_addr;
    exp_t e;
    e.err = v.exp_err;
    e.rdata = v.exp_rdata;
    exp_addr = {v.addr[31:2], 2'b00};
    @(negedge clk);
    sb_q.push_back(e);
    start = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    start = 1'b0;
    req_cycles = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (mem_req) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
        check("mem_wdata", mem_wdata, v.exp_wdata);
        check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
        if (v.poke && req_cycles == 1) begin
          start = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h0000_0040;
        end
        mem_ack = (req_cycles == v.delay);
        mem_rdata = v.mrd;
        req_cycles++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      start = 1'b0;
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", cyc, v.exp_req);
    check("req_cycles", req_cycles, v.exp_req);
    check("req_dropped", {27'd0, mem_req, mem_be}, 32'd0);
    if (v.poke) begin
      start = 1'b1; size = 2'b11;
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", {30'd0, busy, done}, 32'd0);
    check("err_held", {31'd0, err}, {31'd0, v.exp_err});
  endtask

  initial begin
    vt[0]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 1'b0, 4'b1000, 32'hDDDD_DDDD, 32'h0000_0000, 1);
    vt[1]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001, 1);
    vt[2]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0000_8001, 3);
    vt[3]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h0000_007F, 1);
    vt[4]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0000_007F, 0);
    vt[5]  = mk(1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'h1, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0000_007F, 0);
    vt[6]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'h0, 1, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_007F, 2);
    vt[7]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1);
    vt[8]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0, 32'h8000_0000, 1, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 2);
    vt[9]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0, 32'h1111_1111, -1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'hFFFF_FF80, 4);
    vt[10] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_C001, 3, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0000_C001, 4);
    vt[11] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0102_0304, 32'h0, -1, 1'b0, 1'b1, 4'b1111, 32'h0102_0304, 32'h0000_C001, 4);
    vt[12] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0000_C001, 0);
    vt[13] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_005A, 32'h0, 2, 1'b1, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_C001, 3);

    #1;
    check("reset_ctrl", {26'd0, busy, done, err, mem_req, mem_we, 1'b0}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a pending load: no done, outputs fall without an edge.
    @(negedge clk);
    start = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0000_0100;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_req", {30'd0, mem_req, busy}, 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {29'd0, mem_req, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec(vt[i]);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
